bus_arbiter_split: RTL and testbench
====================================

BUS_ARBITER_SPLIT -- requirements
Module: bus_arbiter_split

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max grant cycles without txn_done/split_ack before forced release (range 2..65535).
REQ-002 SHALL have parameter ROUND_ROBIN, default 1, meaning 1 = alternate on contention, 0 = m1 fixed priority.
REQ-003 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports m1_req, m2_req  in  1 each  master bus requests, held high for the whole transaction.
REQ-006 SHALL have ports m1_grant, m2_grant  out  1 each  registered bus grants.
REQ-007 SHALL have port msel  out  1  data/address mux select (0 = m1, 1 = m2), valid whenever any grant is high.
REQ-008 SHALL have port txn_done  in  1  one-cycle pulse from the addressed slave ending the current transaction.
REQ-009 SHALL have port split_ack  in  1  one-cycle pulse from the split slave deferring the current transaction.
REQ-010 SHALL have port split_req  in  1  level from the split slave requesting to complete the deferred transaction.
REQ-011 SHALL have port split_grant  out  1  registered grant to the split slave.
REQ-012 SHALL have ports timeout, split_err  out  1 each  one-cycle error pulses.

Function
REQ-013 SHALL implement states IDLE, GRANT_M1, GRANT_M2, SPLIT_RESUME; outputs SHALL be Moore, decoded from registered state only.
REQ-014 In IDLE, a sampled request SHALL move to the matching GRANT state, so the grant rises the cycle after req is first seen high.
REQ-015 In IDLE with both eligible requests: ROUND_ROBIN=1 SHALL grant the master not granted last; ROUND_ROBIN=0 SHALL grant m1.
REQ-016 A master SHALL be ineligible while it is the recorded split owner; its req SHALL be ignored.
REQ-017 In IDLE with split_pending, split_req high SHALL take priority over all master requests and move to SPLIT_RESUME.
REQ-018 SPLIT_RESUME SHALL assert split_grant and the split owner's grant, with msel = split owner.
REQ-019 In GRANT_Mx, txn_done, or the owner dropping req, SHALL return to IDLE; the grant SHALL fall the following cycle.
REQ-020 In GRANT_Mx, split_ack SHALL record the owner, set split_pending and return to IDLE; it SHALL win over txn_done in the same cycle.
REQ-021 A split_ack while split_pending is already set SHALL pulse split_err, end the transaction as txn_done and leave the recorded owner unchanged.
REQ-022 In SPLIT_RESUME, txn_done SHALL clear split_pending and return to IDLE; split_ack there SHALL pulse split_err and keep split_pending.
REQ-023 A 16-bit grant counter SHALL clear on entering any GRANT or SPLIT_RESUME state and increment each cycle in it.
REQ-024 When the counter equals TIMEOUT_CYCLES-1 with no txn_done or split_ack, the arbiter SHALL pulse timeout, return to IDLE, and clear split_pending if in SPLIT_RESUME.
REQ-025 The last-granted register SHALL update on every GRANT_Mx entry; SPLIT_RESUME SHALL not update it.
REQ-026 An IDLE cycle SHALL always separate two grants, so no back-to-back owner change occurs.

Reset
REQ-027 Reset SHALL force state IDLE, all grants 0, msel 0, split_grant 0, timeout 0, split_err 0, split_pending 0, counter 0, and last-granted = m2, so m1 wins the first contention.
REQ-028 Reset asserted mid-transaction or mid-split SHALL take effect at the next edge and discard the pending split.

Structure
REQ-029 Package bus_arb_pkg SHALL hold the state enum, master-id typedef (M1=0, M2=1) and the counter width constant.
REQ-030 No sub-module is required; the round-robin pick SHALL be a function in bus_arb_pkg.

Verification
REQ-031 Scenario: m1_req at cycle 0, txn_done at cycle 5 -> m1_grant high cycles 1-5, low at 6, msel=0.
REQ-032 Scenario: m1_req and m2_req both high from reset, each given txn_done after 3 granted cycles -> grants in order m1, m2, m1, with one IDLE cycle between each.
REQ-033 Scenario: m1 granted, split_ack at cycle 3, m2_req high -> m1_grant falls at 4, m2_grant rises at 5; m1_req ignored until resume.
REQ-034 Scenario: split pending, split_req and m2_req both high in IDLE -> split_grant=1, m1_grant=1, msel=0; txn_done -> split cleared, m2 granted next.
REQ-035 Scenario: TIMEOUT_CYCLES=4, m2 granted, no txn_done -> timeout pulse on the 4th granted cycle, m2_grant low the next cycle.
REQ-036 Scenario: split pending, second split_ack during m2 grant -> split_err pulse, m2 released, original split owner retained.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types for the two-master split-capable bus arbiter.
// Holds the FSM state, master ids and the round-robin pick.
package bus_arb_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_M1,
        GRANT_M2,
        SPLIT_RESUME
    } arb_state_e;

    typedef enum logic {
        M1 = 1'b0,
        M2 = 1'b1
    } master_e;

    function automatic master_e rr_pick(
        input logic    rr,
        input master_e last,
        input logic    e1,
        input logic    e2
    );
        if (e1 && e2) begin
            if (!rr) return M1;
            if (last == M1) return M2;
            return M1;
        end
        if (e1) return M1;
        return M2;
    endfunction

endpackage

// File: rtl/bus_arbiter_split.sv
// Two-master bus arbiter with one split slave, round-robin or
// fixed priority, and a per-grant watchdog.
module bus_arbiter_split
    import bus_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ROUND_ROBIN    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic m1_req,
    input  logic m2_req,
    input  logic txn_done,
    input  logic split_ack,
    input  logic split_req,
    output logic m1_grant,
    output logic m2_grant,
    output logic msel,
    output logic split_grant,
    output logic timeout,
    output logic split_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    master_e          last_q, last_d;
    master_e          owner_q, owner_d;
    logic             pend_q, pend_d;

    master_e win;
    master_e cur;
    logic    cur_req;
    logic    e1, e2;
    logic    hit;

    // The split owner may not re-arbitrate until its transaction resumes.
    assign e1      = m1_req && !(pend_q && owner_q == M1);
    assign e2      = m2_req && !(pend_q && owner_q == M2);
    assign cur     = master_e'(state_q == GRANT_M2);
    assign cur_req = (cur == M1) ? m1_req : m2_req;
    assign hit     = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        last_d    = last_q;
        owner_d   = owner_q;
        pend_d    = pend_q;
        timeout   = 1'b0;
        split_err = 1'b0;
        win       = M1;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pend_q && split_req) begin
                    state_d = SPLIT_RESUME;
                end else if (e1 || e2) begin
                    win     = rr_pick(ROUND_ROBIN != 0, last_q, e1, e2);
                    state_d = (win == M1) ? GRANT_M1 : GRANT_M2;
                    last_d  = win;
                end
            end
            GRANT_M1, GRANT_M2: begin
                if (split_ack) begin
                    state_d = IDLE;
                    if (pend_q) begin
                        split_err = 1'b1;
                    end else begin
                        pend_d  = 1'b1;
                        owner_d = cur;
                    end
                end else if (txn_done) begin
                    state_d = IDLE;
                end else if (hit) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else if (!cur_req) begin
                    state_d = IDLE;
                end
            end
            SPLIT_RESUME: begin
                if (split_ack) begin
                    split_err = 1'b1;
                    state_d   = IDLE;
                end else if (txn_done) begin
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end else if (hit) begin
                    timeout = 1'b1;
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= M2;
            owner_q <= M1;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            pend_q  <= pend_d;
        end
    end

    // Grants follow the registered state; a resume grants the split owner.
    assign split_grant = (state_q == SPLIT_RESUME);
    assign m1_grant    = (state_q == GRANT_M1) ||
                         (split_grant && owner_q == M1);
    assign m2_grant    = (state_q == GRANT_M2) ||
                         (split_grant && owner_q == M2);
    assign msel        = m2_grant;

endmodule

// File: tb/tb_bus_arbiter_split.sv
// Bench for bus_arbiter_split: two instances (T=8 round-robin,
// T=4 fixed priority) checked every cycle against a bus-holder model.
module tb_bus_arbiter_split;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic m1_req = 1'b0;
    logic m2_req = 1'b0;
    logic txn_done = 1'b0;
    logic split_ack = 1'b0;
    logic split_req = 1'b0;

    logic [1:0] g1, g2, ms, sg, to, se;

    bus_arbiter_split #(.TIMEOUT_CYCLES(8), .ROUND_ROBIN(1)) u_rr (
        .clk(clk), .rst(rst),
        .m1_req(m1_req), .m2_req(m2_req),
        .txn_done(txn_done), .split_ack(split_ack),
        .split_req(split_req),
        .m1_grant(g1[0]), .m2_grant(g2[0]), .msel(ms[0]),
        .split_grant(sg[0]), .timeout(to[0]), .split_err(se[0])
    );

    bus_arbiter_split #(.TIMEOUT_CYCLES(4), .ROUND_ROBIN(0)) u_fp (
        .clk(clk), .rst(rst),
        .m1_req(m1_req), .m2_req(m2_req),
        .txn_done(txn_done), .split_ack(split_ack),
        .split_req(split_req),
        .m1_grant(g1[1]), .m2_grant(g2[1]), .msel(ms[1]),
        .split_grant(sg[1]), .timeout(to[1]), .split_err(se[1])
    );

    // Model: who holds the bus (0 none, 1 m1, 2 m2), how long,
    // and the deferred-transaction bookkeeping.
    int holder[2];
    int age[2];
    int last[2];
    int sown[2];
    bit resume[2];
    bit pend[2];
    int tmo[2] = '{8, 4};
    bit rr[2]  = '{1'b1, 1'b0};

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;
    logic [5:0] obs0, obs1;

    // Vector order: m1_grant m2_grant msel split_grant timeout split_err
    function automatic logic [5:0] expv(int k);
        logic t, e;
        t = holder[k] != 0 && age[k] == tmo[k] - 1 &&
            !txn_done && !split_ack;
        e = holder[k] != 0 && split_ack && pend[k];
        return {holder[k] == 1, holder[k] == 2, holder[k] == 2,
                resume[k], t, e};
    endfunction

    function automatic logic [5:0] dutv(int k);
        return {g1[k], g2[k], ms[k], sg[k], to[k], se[k]};
    endfunction

    task automatic check(string name, logic [5:0] got, logic [5:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
    endtask

    task automatic step_model();
        bit w1, w2, req_h, fin;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                holder[k] = 0; age[k] = 0; last[k] = 2;
                sown[k] = 1; resume[k] = 0; pend[k] = 0;
            end else if (holder[k] == 0) begin
                age[k] = 0;
                if (pend[k] && split_req) begin
                    holder[k] = sown[k];
                    resume[k] = 1;
                end else begin
                    w1 = m1_req && !(pend[k] && sown[k] == 1);
                    w2 = m2_req && !(pend[k] && sown[k] == 2);
                    if (w1 && w2) holder[k] = rr[k] ? 3 - last[k] : 1;
                    else if (w1) holder[k] = 1;
                    else if (w2) holder[k] = 2;
                    if (holder[k] != 0) last[k] = holder[k];
                end
            end else begin
                req_h = (holder[k] == 1) ? m1_req : m2_req;
                fin = split_ack || txn_done || age[k] == tmo[k] - 1 ||
                      (!resume[k] && !req_h);
                if (split_ack && !pend[k] && !resume[k]) begin
                    pend[k] = 1;
                    sown[k] = holder[k];
                end
                if (resume[k] && !split_ack &&
                    (txn_done || age[k] == tmo[k] - 1)) pend[k] = 0;
                if (fin) begin
                    holder[k] = 0;
                    resume[k] = 0;
                end else begin
                    age[k]++;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            check("model_rr", dutv(0), expv(0));
            check("model_fp", dutv(1), expv(1));
        end
        obs0 = dutv(0);
        obs1 = dutv(1);
        @(posedge clk);
        step_model();
        #1;
        cyc++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m1_req = 0; m2_req = 0; txn_done = 0;
        split_ack = 0; split_req = 0;
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_rr", obs0, 6'b000000);
        check("reset_fp", obs1, 6'b000000);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // single m1 transaction
        do_reset();
        m1_req = 1; tick(); check("A_c0", obs0, 6'b000000);
        tick(); check("A_c1", obs0, 6'b100000);
        run(3);
        txn_done = 1; tick(); check("A_c5", obs0, 6'b100000);
        txn_done = 0; m1_req = 0;
        tick(); check("A_c6", obs0, 6'b000000);
        run(2);

        // contention: alternate vs fixed priority
        do_reset();
        m1_req = 1; m2_req = 1; tick();
        tick(); check("B_c1", obs0, 6'b100000);
        tick();
        txn_done = 1; tick(); txn_done = 0;
        tick(); check("B_c4", obs0, 6'b000000);
        tick(); check("B_c5", obs0, 6'b011000);
        check("B_c5_fp", obs1, 6'b100000);
        tick();
        txn_done = 1; tick(); txn_done = 0;
        tick(); check("B_c8", obs0, 6'b000000);
        tick(); check("B_c9", obs0, 6'b100000);
        tick();
        txn_done = 1; tick(); txn_done = 0;
        m1_req = 0; m2_req = 0;
        run(2);

        // split by m1, m2 served, then resume beats m2
        do_reset();
        m1_req = 1; m2_req = 1; tick();
        tick(); check("C_c1", obs0, 6'b100000);
        tick();
        split_ack = 1; tick(); check("C_c3", obs0, 6'b100000);
        split_ack = 0;
        tick(); check("C_c4", obs0, 6'b000000);
        tick(); check("C_c5", obs0, 6'b011000);
        tick();
        txn_done = 1; tick(); txn_done = 0; m2_req = 0;
        tick();
        split_req = 1; m2_req = 1;
        tick(); check("C_c9", obs0, 6'b000000);
        tick(); check("D_c10", obs0, 6'b100100);
        txn_done = 1; split_req = 0; tick();
        txn_done = 0; m1_req = 0;
        tick(); check("D_c12", obs0, 6'b000000);
        tick(); check("D_c13", obs0, 6'b011000);
        txn_done = 1; tick(); txn_done = 0; m2_req = 0;
        run(2);

        // second split while pending, then split_ack during resume
        do_reset();
        m1_req = 1; m2_req = 1; tick();
        split_ack = 1; tick(); split_ack = 0;
        tick();
        tick(); check("E_c3", obs0, 6'b011000);
        split_ack = 1; tick(); check("E_c4", obs0, 6'b011001);
        split_ack = 0; m2_req = 0; split_req = 1;
        tick(); check("E_c5", obs0, 6'b000000);
        tick(); check("E_c6", obs0, 6'b100100);
        split_ack = 1; tick(); check("E_c7", obs0, 6'b100101);
        split_ack = 0;
        tick(); check("E_c8", obs0, 6'b000000);
        tick(); check("E_c9", obs0, 6'b100100);
        txn_done = 1; split_req = 0; tick();
        txn_done = 0; m1_req = 0;
        tick(); check("E_c11", obs0, 6'b000000);
        run(1);

        // watchdog on a normal grant (T=4 instance)
        do_reset();
        m2_req = 1; tick();
        tick(); check("F_c1", obs1, 6'b011000);
        run(2);
        tick(); check("F_c4", obs1, 6'b011010);
        m2_req = 0;
        tick(); check("F_c5", obs1, 6'b000000);
        run(2);

        // reset in the middle of a pending split discards it
        do_reset();
        m1_req = 1; run(2);
        split_ack = 1; tick(); split_ack = 0;
        rst = 1; tick(); rst = 0;
        split_req = 1;
        tick(); check("G_c4", obs0, 6'b000000);
        tick(); check("G_c5", obs0, 6'b100000);
        split_req = 0; m1_req = 0;
        run(2);

        // watchdog during a resume clears the pending split
        do_reset();
        m1_req = 1; tick();
        split_ack = 1; tick(); split_ack = 0; m1_req = 0;
        split_req = 1; tick();
        tick(); check("H_c3_rr", obs0, 6'b100100);
        check("H_c3_fp", obs1, 6'b100100);
        run(2);
        tick(); check("H_c6", obs1, 6'b100110);
        tick(); check("H_c7", obs1, 6'b000000);
        run(2);
        tick(); check("H_c10", obs0, 6'b100110);
        tick(); check("H_c11", obs0, 6'b000000);
        check("H_c11_fp", obs1, 6'b000000);
        split_req = 0;
        run(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
